// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one ALU with round-robin grant; ALU_ARB_STATS_EN adds saturating grant counters.
// Latency 1 cycle (registered result); a held result blocks new grants until resp_ready retires it.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_aluop,
  input  logic [5:0]       req0_func,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_aluop,
  input  logic [5:0]       req1_func,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  input  logic             resp_ready,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             last_grant_q, last_grant_d;
  logic             accept, any_gnt;
  logic [WIDTH-1:0] alu_res;

  function automatic logic [WIDTH-1:0] alu_eval(input logic [1:0] aluop, input logic [5:0] func,
                                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] slt_res;
    logic [WIDTH-1:0] r;
    slt_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
    case (aluop)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b11:   r = slt_res;
      default: begin
        case (func)
          6'b100000: r = a + b;
          6'b100011: r = a - b;
          6'b100101: r = a | b;
          6'b101010: r = slt_res;
          default:   r = a & b;
        endcase
      end
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_id_q    <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      resp_id_q    <= resp_id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    resp_id_d    = resp_id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    last_grant_d = last_grant_q;
    alu_res      = req1_ready ? alu_eval(req1_aluop, req1_func, req1_a, req1_b)
                              : alu_eval(req0_aluop, req0_func, req0_a, req0_b);
    if (any_gnt) begin
      state_d      = HOLD;
      resp_id_d    = req1_ready;
      result_d     = alu_res;
      zero_d       = (alu_res == '0);
      last_grant_d = req1_ready;
    end else if (state_q == HOLD && resp_ready) begin
      state_d = IDLE;
    end
  end

  // Ties go to the requester that did not win last; a lone requester always wins.
  always_comb begin
    accept      = !rst && (state_q == IDLE || resp_ready);
    req0_ready  = accept && req0_valid && (!req1_valid || last_grant_q);
    req1_ready  = accept && req1_valid && (!req0_valid || !last_grant_q);
    any_gnt     = req0_ready || req1_ready;
    resp_valid  = (state_q == HOLD);
    resp_id     = resp_id_q;
    resp_result = result_q;
    resp_zero   = zero_q;
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (req1_ready && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = 16'd0;
  assign grant_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a spec-level model checked every negedge plus literal expectations.
module tb_alu_share_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]   req0_aluop, req1_aluop;
  logic [5:0]   req0_func, req1_func;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp_valid, resp_id, resp_zero, resp_ready;
  logic [W-1:0] resp_result;
  logic [15:0]  grant_cnt0, grant_cnt1;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_ready(resp_ready),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return (sa < sb) ? 1 : 0;
    if (f == 6'd32) return a + b;
    if (f == 6'd35) return a - b;
    if (f == 6'd37) return a | b;
    if (f == 6'd42) return (sa < sb) ? 1 : 0;
    return a & b;
  endfunction

  // Model: what the consumer should see, updated at each clock edge.
  logic         m_valid, m_id, m_last;
  logic [W-1:0] m_result;
  int           m_cnt0, m_cnt1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_id = 0; m_result = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else begin : upd
      int g;
      bit take;
      take = !m_valid || resp_ready;
      g = -1;
      if (take) begin
        if (req0_valid && req1_valid) g = m_last ? 0 : 1;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
      end
      if (g == 0) begin
        m_result = ref_alu(req0_aluop, req0_func, req0_a, req0_b);
        if (STATS && m_cnt0 < 65535) m_cnt0++;
      end else if (g == 1) begin
        m_result = ref_alu(req1_aluop, req1_func, req1_a, req1_b);
        if (STATS && m_cnt1 < 65535) m_cnt1++;
      end
      if (g >= 0) begin
        m_valid = 1; m_id = g[0]; m_last = g[0];
      end else if (take) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic take, e0, e1;
    take = !rst && (!m_valid || resp_ready);
    e0 = take && req0_valid && (!req1_valid || m_last);
    e1 = take && req1_valid && (!req0_valid || !m_last);
    check("cmp_req0_ready", req0_ready, e0);
    check("cmp_req1_ready", req1_ready, e1);
    check("cmp_resp_valid", resp_valid, m_valid);
    if (m_valid) begin
      check("cmp_resp_id", resp_id, m_id);
      check("cmp_resp_result", resp_result, m_result);
      check("cmp_resp_zero", resp_zero, m_result == 0);
    end
    check("cmp_grant_cnt0", grant_cnt0, m_cnt0);
    check("cmp_grant_cnt1", grant_cnt1, m_cnt1);
  end

  task automatic set_req(input int n, input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      req0_valid = v; req0_aluop = op; req0_func = f; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_aluop = op; req1_func = f; req1_a = a; req1_b = b;
    end
  endtask

  typedef struct {logic [1:0] op; logic [5:0] f; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp;} vec_t;
  vec_t vecs[9];

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1};
    vecs[1] = '{2'b10, 6'b100011, 32'd3, 32'd3, 32'd0};
    vecs[2] = '{2'b10, 6'b000000, 32'd6, 32'd3, 32'd2};
    vecs[3] = '{2'b01, 6'b000000, 32'd10, 32'd3, 32'd7};
    vecs[4] = '{2'b11, 6'b000000, 32'hFFFFFFFE, 32'd1, 32'd1};
    vecs[5] = '{2'b11, 6'b000000, 32'd5, 32'hFFFFFFFD, 32'd0};
    vecs[6] = '{2'b10, 6'b100100, 32'hF0, 32'h3C, 32'h30};
    vecs[7] = '{2'b10, 6'b100101, 32'hF0, 32'h0F, 32'hFF};
    vecs[8] = '{2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1, 32'd0};

    rst = 1; resp_ready = 0;
    set_req(0, 1, 2'b00, 6'd0, 32'd1, 32'd1);
    set_req(1, 0, 2'b00, 6'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_zero", resp_zero, 0);
    check("rst_req0_ready", req0_ready, 0);
    #1 rst = 0; req0_valid = 0;

    // Single add from req0.
    resp_ready = 1;
    set_req(0, 1, 2'b00, 6'd0, 32'd5, 32'd7);
    #1 check("t1_req0_ready", req0_ready, 1);
    @(negedge clk);
    check("t1_valid", resp_valid, 1);
    check("t1_id", resp_id, 0);
    check("t1_result", resp_result, 12);
    check("t1_zero", resp_zero, 0);
    #1 req0_valid = 0;
    @(negedge clk);

    // Fresh reset, then both valid every cycle: strict alternation from req0.
    #1 rst = 1;
    @(negedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 2'b00, 6'd0, W'(i), 32'd10);
      set_req(1, 1, 2'b01, 6'd0, 32'd100, W'(i));
      @(negedge clk);
      check("t2_valid", resp_valid, 1);
      check("t2_id", resp_id, i % 2);
      #1;
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);

    // Back-to-back single-requester ops with literal results.
    #1;
    for (int i = 0; i < 9; i++) begin
      set_req(i < 3 ? 1 : 0, 1, vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b);
      set_req(i < 3 ? 0 : 1, 0, 2'b00, 6'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("t3_result", resp_result, vecs[i].exp);
      check("t3_zero", resp_zero, vecs[i].exp == 0);
      #1;
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);

    // Backpressure: held result stays put, pending req0 waits, then swaps in on one edge.
    #1 resp_ready = 0;
    set_req(0, 1, 2'b00, 6'd0, 32'd1, 32'd2);
    @(negedge clk);
    check("t4_first", resp_result, 3);
    #1 set_req(0, 1, 2'b00, 6'd0, 32'd40, 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_stall_ready", req0_ready, 0);
      check("t4_stall_result", resp_result, 3);
      check("t4_stall_valid", resp_valid, 1);
    end
    #1 resp_ready = 1;
    #1 check("t4_swap_ready", req0_ready, 1);
    @(negedge clk);
    check("t4_swap_result", resp_result, 42);
    #1 resp_ready = 0;
    set_req(0, 0, 2'b01, 6'd0, 32'd999, 32'd1);
    @(negedge clk);
    check("t4_sampled_once", resp_result, 42);
    #1 resp_ready = 1;
    @(negedge clk);

    // Reset while holding, then tie goes to req0 and counters restart.
    #1 resp_ready = 0;
    set_req(1, 1, 2'b00, 6'd0, 32'd1, 32'd1);
    @(negedge clk);
    check("t5_hold", resp_valid, 1);
    #1 rst = 1;
    #1 check("t5_rst_valid", resp_valid, 0);
    check("t5_rst_ready", req1_ready, 0);
    @(negedge clk);
    #1 rst = 0; resp_ready = 1;
    set_req(0, 1, 2'b00, 6'd0, 32'd2, 32'd2);
    #1 check("t5_tie_req0", req0_ready, 1);
    check("t5_tie_req1", req1_ready, 0);
    @(negedge clk);
    check("t5_tie_id", resp_id, 0);
    #1 req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_req1_id", resp_id, 1);
      #1;
    end
    req1_valid = 0;
    @(negedge clk);
    check("t5_cnt0", grant_cnt0, STATS ? 1 : 0);
    check("t5_cnt1", grant_cnt1, STATS ? 3 : 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
